// File: rtl/traffic_signal_monitor.sv
// Conflict monitor between the intersection controller and the lamp drivers.
// It decodes the phase code to lamp drives, checks the phase order and dwell bounds, and latches a flashing-red failsafe.
module traffic_signal_monitor #(
  parameter int RED_MIN    = 4,
  parameter int RED_MAX    = 8,
  parameter int YEL_MIN    = 1,
  parameter int YEL_MAX    = 2,
  parameter int GRN_MIN    = 6,
  parameter int GRN_MAX    = 11,
  parameter int CNT_W      = 8,
  parameter int FLASH_HALF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       signal_in,
  output logic             lamp_red,
  output logic             lamp_yel,
  output logic             lamp_grn,
  output logic             phase_done,
  output logic [CNT_W-1:0] last_dwell,
  output logic [15:0]      cycle_count,
  output logic             fault,
  output logic [2:0]       fault_code
);

  localparam int CW1 = CNT_W + 1;

  localparam logic [1:0] PH_RED = 2'b00;
  localparam logic [1:0] PH_YEL = 2'b01;
  localparam logic [1:0] PH_GRN = 2'b10;
  localparam logic [1:0] PH_BAD = 2'b11;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ILLEGAL  = 3'd1;
  localparam logic [2:0] FC_SEQUENCE = 3'd2;
  localparam logic [2:0] FC_SHORT    = 3'd3;
  localparam logic [2:0] FC_TIMEOUT  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  function automatic logic [CW1-1:0] dwell_max(input logic [1:0] ph);
    case (ph)
      PH_RED:  return CW1'(RED_MAX);
      PH_YEL:  return CW1'(YEL_MAX);
      default: return CW1'(GRN_MAX);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dwell_min(input logic [1:0] ph);
    case (ph)
      PH_RED:  return CNT_W'(RED_MIN);
      PH_YEL:  return CNT_W'(YEL_MIN);
      default: return CNT_W'(GRN_MIN);
    endcase
  endfunction

  function automatic logic [1:0] successor(input logic [1:0] ph);
    case (ph)
      PH_RED:  return PH_YEL;
      PH_YEL:  return PH_GRN;
      PH_GRN:  return PH_RED;
      default: return PH_BAD;
    endcase
  endfunction

  // Lamp vector is {grn, yel, red}.
  function automatic logic [2:0] lamp_decode(input logic [1:0] ph);
    case (ph)
      PH_RED:  return 3'b001;
      PH_YEL:  return 3'b010;
      PH_GRN:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  state_t           state_p0, state_p1;
  logic [1:0]       cur_p0, cur_p1;
  logic [CNT_W-1:0] cnt_p0, cnt_p1;
  logic [2:0]       lamps_p0, lamps_p1;
  logic             phase_done_p0, phase_done_p1;
  logic [CNT_W-1:0] last_dwell_p0, last_dwell_p1;
  logic [15:0]      cycle_count_p0, cycle_count_p1;
  logic             fault_p0, fault_p1;
  logic [2:0]       fault_code_p0, fault_code_p1;
  logic [CNT_W-1:0] flash_p0, flash_p1;
  logic [CW1-1:0]   cnt_inc;
  logic             fault_hit;
  logic [2:0]       fault_sel;

  // Stage p0: next-state and next-output evaluation.
  always_comb begin
    state_p0       = state_p1;
    cur_p0         = cur_p1;
    cnt_p0         = cnt_p1;
    lamps_p0       = lamps_p1;
    phase_done_p0  = 1'b0;
    last_dwell_p0  = last_dwell_p1;
    cycle_count_p0 = cycle_count_p1;
    fault_p0       = fault_p1;
    fault_code_p0  = fault_code_p1;
    flash_p0       = flash_p1;
    fault_hit      = 1'b0;
    fault_sel      = FC_NONE;
    cnt_inc        = {1'b0, cnt_p1} + CW1'(1);

    case (state_p1)
      ST_INIT: begin
        lamps_p0 = 3'b001;
        if (signal_in == PH_BAD) begin
          fault_hit = 1'b1;
          fault_sel = FC_ILLEGAL;
        end else if (signal_in == PH_RED) begin
          state_p0 = ST_RUN;
          cur_p0   = PH_RED;
          cnt_p0   = CNT_ONE;
          lamps_p0 = lamp_decode(PH_RED);
        end
      end

      ST_RUN: begin
        if (signal_in == PH_BAD) begin
          fault_hit = 1'b1;
          fault_sel = FC_ILLEGAL;
        end else if (signal_in == cur_p1) begin
          if (cnt_inc > dwell_max(cur_p1)) begin
            fault_hit = 1'b1;
            fault_sel = FC_TIMEOUT;
          end else begin
            cnt_p0   = cnt_inc[CNT_W-1:0];
            lamps_p0 = lamp_decode(signal_in);
          end
        end else if (signal_in != successor(cur_p1)) begin
          fault_hit = 1'b1;
          fault_sel = FC_SEQUENCE;
        end else if (cnt_p1 < dwell_min(cur_p1)) begin
          fault_hit = 1'b1;
          fault_sel = FC_SHORT;
        end else begin
          last_dwell_p0 = cnt_p1;
          phase_done_p0 = 1'b1;
          cur_p0        = signal_in;
          cnt_p0        = CNT_ONE;
          lamps_p0      = lamp_decode(signal_in);
          if (cur_p1 == PH_GRN) begin
            cycle_count_p0 = cycle_count_p1 + 16'd1;
          end
        end
      end

      ST_FAULT: begin
        // Red flashes with period 2*FLASH_HALF; first fault cycle is lit.
        if (flash_p1 == FLASH_LAST) begin
          flash_p0 = '0;
          lamps_p0 = {2'b00, ~lamps_p1[0]};
        end else begin
          flash_p0 = flash_p1 + CNT_ONE;
          lamps_p0 = {2'b00, lamps_p1[0]};
        end
      end

      default: begin
        state_p0 = ST_INIT;
      end
    endcase

    if (fault_hit) begin
      state_p0      = ST_FAULT;
      fault_p0      = 1'b1;
      fault_code_p0 = fault_sel;
      lamps_p0      = 3'b001;
      flash_p0      = '0;
      phase_done_p0 = 1'b0;
    end
  end

  // Stage p1: registered state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1       <= ST_INIT;
      cur_p1         <= PH_RED;
      cnt_p1         <= '0;
      lamps_p1       <= 3'b001;
      phase_done_p1  <= 1'b0;
      last_dwell_p1  <= '0;
      cycle_count_p1 <= '0;
      fault_p1       <= 1'b0;
      fault_code_p1  <= FC_NONE;
      flash_p1       <= '0;
    end else begin
      state_p1       <= state_p0;
      cur_p1         <= cur_p0;
      cnt_p1         <= cnt_p0;
      lamps_p1       <= lamps_p0;
      phase_done_p1  <= phase_done_p0;
      last_dwell_p1  <= last_dwell_p0;
      cycle_count_p1 <= cycle_count_p0;
      fault_p1       <= fault_p0;
      fault_code_p1  <= fault_code_p0;
      flash_p1       <= flash_p0;
    end
  end

  assign lamp_red    = lamps_p1[0];
  assign lamp_yel    = lamps_p1[1];
  assign lamp_grn    = lamps_p1[2];
  assign phase_done  = phase_done_p1;
  assign last_dwell  = last_dwell_p1;
  assign cycle_count = cycle_count_p1;
  assign fault       = fault_p1;
  assign fault_code  = fault_code_p1;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Directed bench for traffic_signal_monitor: a reference model pushes expected outputs
// per edge into a queue, which are popped and compared after each edge.
module tb_traffic_signal_monitor;

  localparam int RED_MIN    = 4;
  localparam int RED_MAX    = 8;
  localparam int YEL_MIN    = 1;
  localparam int YEL_MAX    = 2;
  localparam int GRN_MIN    = 6;
  localparam int GRN_MAX    = 11;
  localparam int CNT_W      = 8;
  localparam int FLASH_HALF = 2;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic             clk;
  logic             rst;
  logic [1:0]       signal_in;
  logic             lamp_red;
  logic             lamp_yel;
  logic             lamp_grn;
  logic             phase_done;
  logic [CNT_W-1:0] last_dwell;
  logic [15:0]      cycle_count;
  logic             fault;
  logic [2:0]       fault_code;

  traffic_signal_monitor #(
    .RED_MIN(RED_MIN), .RED_MAX(RED_MAX), .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX),
    .GRN_MIN(GRN_MIN), .GRN_MAX(GRN_MAX), .CNT_W(CNT_W), .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in),
    .lamp_red(lamp_red), .lamp_yel(lamp_yel), .lamp_grn(lamp_grn),
    .phase_done(phase_done), .last_dwell(last_dwell), .cycle_count(cycle_count),
    .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int red; int yel; int grn; int pd; int ld; int cc; int f; int fc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 INIT, 1 RUN, 2 FAULT.
  int m_state = 0, m_cur = 0, m_cnt = 0, m_fl = 0;
  int m_red = 1, m_yel = 0, m_grn = 0, m_pd = 0, m_ld = 0, m_cc = 0, m_f = 0, m_fc = 0;

  function automatic int ph_max(input int p);
    return (p == 0) ? RED_MAX : (p == 1) ? YEL_MAX : GRN_MAX;
  endfunction

  function automatic int ph_min(input int p);
    return (p == 0) ? RED_MIN : (p == 1) ? YEL_MIN : GRN_MIN;
  endfunction

  task automatic m_lamps(input int p);
    m_red = (p == 0) ? 1 : 0;
    m_yel = (p == 1) ? 1 : 0;
    m_grn = (p == 2) ? 1 : 0;
  endtask

  task automatic m_trip(input int code);
    m_state = 2; m_f = 1; m_fc = code; m_fl = 0;
    m_red = 1; m_yel = 0; m_grn = 0; m_pd = 0;
  endtask

  task automatic model_edge(input int s, input bit r);
    if (r) begin
      m_state = 0; m_cur = 0; m_cnt = 0; m_fl = 0;
      m_red = 1; m_yel = 0; m_grn = 0; m_pd = 0; m_ld = 0; m_cc = 0; m_f = 0; m_fc = 0;
      return;
    end
    m_pd = 0;
    if (m_state == 0) begin
      if (s == 3) m_trip(1);
      else if (s == 0) begin m_state = 1; m_cur = 0; m_cnt = 1; m_lamps(0); end
      else m_lamps(0);
    end else if (m_state == 1) begin
      if (s == 3) m_trip(1);
      else if (s == m_cur) begin
        if (m_cnt + 1 > ph_max(m_cur)) m_trip(4);
        else begin m_cnt++; m_lamps(s); end
      end else if (s != (m_cur + 1) % 3) m_trip(2);
      else if (m_cnt < ph_min(m_cur)) m_trip(3);
      else begin
        m_ld = m_cnt; m_pd = 1;
        if (m_cur == 2) m_cc = (m_cc + 1) % 65536;
        m_cur = s; m_cnt = 1; m_lamps(s);
      end
    end else begin
      m_yel = 0; m_grn = 0;
      if (m_fl == FLASH_HALF - 1) begin m_fl = 0; m_red = 1 - m_red; end
      else m_fl++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] s, input logic r);
    exp_t e;
    @(negedge clk);
    signal_in = s;
    rst = r;
    model_edge(int'(s), r);
    e.red = m_red; e.yel = m_yel; e.grn = m_grn; e.pd = m_pd;
    e.ld = m_ld; e.cc = m_cc; e.f = m_f; e.fc = m_fc;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("lamp_red", 32'(lamp_red), 32'(e.red));
    chk("lamp_yel", 32'(lamp_yel), 32'(e.yel));
    chk("lamp_grn", 32'(lamp_grn), 32'(e.grn));
    chk("phase_done", 32'(phase_done), 32'(e.pd));
    chk("last_dwell", 32'(last_dwell), 32'(e.ld));
    chk("cycle_count", 32'(cycle_count), 32'(e.cc));
    chk("fault", 32'(fault), 32'(e.f));
    chk("fault_code", 32'(fault_code), 32'(e.fc));
  endtask

  initial begin
    rst = 1'b1;
    signal_in = R;

    // Reset state
    step(R, 1'b1);
    step(R, 1'b1);
    chk("rst_red", 32'(lamp_red), 32'd1);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cc", 32'(cycle_count), 32'd0);

    // Full legal cycle
    repeat (5) step(R, 1'b0);
    step(Y, 1'b0);
    chk("c1_pd_yel", 32'(phase_done), 32'd1);
    chk("c1_ld_red", 32'(last_dwell), 32'd5);
    chk("c1_lamp_yel", 32'(lamp_yel), 32'd1);
    step(G, 1'b0);
    chk("c1_ld_yel", 32'(last_dwell), 32'd1);
    repeat (6) step(G, 1'b0);
    chk("c1_pd_low", 32'(phase_done), 32'd0);
    step(R, 1'b0);
    chk("c1_ld_grn", 32'(last_dwell), 32'd7);
    chk("c1_cc", 32'(cycle_count), 32'd1);
    chk("c1_fault", 32'(fault), 32'd0);
    repeat (3) step(R, 1'b0);

    // Bad sequence RED->GREEN, then the flash pattern
    step(R, 1'b1);
    repeat (5) step(R, 1'b0);
    step(G, 1'b0);
    chk("seq_fault", 32'(fault), 32'd1);
    chk("seq_code", 32'(fault_code), 32'd2);
    chk("seq_flash0", 32'(lamp_red), 32'd1);
    chk("seq_grn", 32'(lamp_grn), 32'd0);
    step(G, 1'b0);
    chk("seq_flash1", 32'(lamp_red), 32'd1);
    step(Y, 1'b0);
    chk("seq_flash2", 32'(lamp_red), 32'd0);
    step(R, 1'b0);
    chk("seq_flash3", 32'(lamp_red), 32'd0);
    step(G, 1'b0);
    chk("seq_flash4", 32'(lamp_red), 32'd1);
    chk("seq_cc", 32'(cycle_count), 32'd0);
    repeat (3) step(R, 1'b0);

    // Short RED dwell
    step(R, 1'b1);
    repeat (3) step(R, 1'b0);
    step(Y, 1'b0);
    chk("short_code", 32'(fault_code), 32'd3);
    chk("short_ld", 32'(last_dwell), 32'd0);
    chk("short_yel", 32'(lamp_yel), 32'd0);

    // GREEN timeout: 11 samples legal, 12th trips
    step(R, 1'b1);
    repeat (5) step(R, 1'b0);
    step(Y, 1'b0);
    repeat (11) step(G, 1'b0);
    chk("tmo_no_fault_11", 32'(fault), 32'd0);
    step(G, 1'b0);
    chk("tmo_fault_12", 32'(fault), 32'd1);
    chk("tmo_code", 32'(fault_code), 32'd4);

    // Illegal code, sticky fault, then reset exits
    step(R, 1'b1);
    repeat (2) step(R, 1'b0);
    step(X, 1'b0);
    chk("ill_code", 32'(fault_code), 32'd1);
    repeat (20) step(R, 1'b0);
    chk("ill_sticky", 32'(fault), 32'd1);
    chk("ill_code_held", 32'(fault_code), 32'd1);
    step(R, 1'b1);
    chk("ill_rst_fault", 32'(fault), 32'd0);
    chk("ill_rst_code", 32'(fault_code), 32'd0);
    chk("ill_rst_red", 32'(lamp_red), 32'd1);

    // INIT ignores GREEN until the first RED
    repeat (10) step(G, 1'b0);
    chk("init_red", 32'(lamp_red), 32'd1);
    chk("init_grn", 32'(lamp_grn), 32'd0);
    chk("init_fault", 32'(fault), 32'd0);
    repeat (4) step(R, 1'b0);
    step(Y, 1'b0);
    chk("init_pd", 32'(phase_done), 32'd1);
    chk("init_ld", 32'(last_dwell), 32'd4);
    step(Y, 1'b0);
    repeat (6) step(G, 1'b0);
    step(R, 1'b0);
    chk("init_cc", 32'(cycle_count), 32'd1);
    chk("init_ld_grn", 32'(last_dwell), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
